// File: rtl/card_dealer.sv
// Random card dealer: LFSR-seeded pick with linear probe over a used-card bitmap.
// Define CARD_DEALER_AUTO_REFILL_EN to refill the deck on a request made while empty.
module card_dealer #(
  parameter int unsigned  COLOR_W   = 2,
  parameter int unsigned  NUMBER_W  = 3,
  parameter logic [15:0]  SEED      = 16'hACE1,
  localparam int unsigned IDX_W     = COLOR_W + NUMBER_W,
  localparam int unsigned DECK_SIZE = 2 ** IDX_W,
  localparam int unsigned CNT_W     = IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                shuffle,
  output logic                valid,
  output logic [COLOR_W-1:0]  color,
  output logic [NUMBER_W-1:0] number,
  output logic [CNT_W-1:0]    remaining,
  output logic                empty,
  output logic                busy,
  output logic                err
);

  typedef enum logic {IDLE, PROBE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [DECK_SIZE-1:0]  used_q, used_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [COLOR_W-1:0]    color_q, color_d;
  logic [NUMBER_W-1:0]   number_q, number_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  empty_w;

  assign empty_w = (rem_q == '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    used_d   = used_q;
    rem_d    = rem_q;
    color_d  = color_q;
    number_d = number_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    // Galois form of x^16+x^14+x^13+x^11+1; a non-zero seed never reaches zero
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    case (state_q)
      IDLE: begin
        if (shuffle) begin
          used_d = '0;
          rem_d  = CNT_W'(DECK_SIZE);
        end else if (req) begin
          if (!empty_w) begin
            idx_d   = lfsr_q[IDX_W-1:0];
            state_d = PROBE;
          end else begin
`ifdef CARD_DEALER_AUTO_REFILL_EN
            used_d  = '0;
            rem_d   = CNT_W'(DECK_SIZE);
            idx_d   = lfsr_q[IDX_W-1:0];
            state_d = PROBE;
`else
            err_d   = 1'b1;
`endif
          end
        end
      end
      PROBE: begin
        // A free card always exists here, so the probe terminates and rem_q >= 1
        if (!used_q[idx_q]) begin
          used_d[idx_q] = 1'b1;
          color_d       = idx_q[IDX_W-1:NUMBER_W];
          number_d      = idx_q[NUMBER_W-1:0];
          valid_d       = 1'b1;
          rem_d         = rem_q - CNT_W'(1);
          state_d       = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      used_q   <= '0;
      idx_q    <= '0;
      rem_q    <= CNT_W'(DECK_SIZE);
      color_q  <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      color_q  <= color_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign valid     = valid_q;
  assign color     = color_q;
  assign number    = number_q;
  assign remaining = rem_q;
  assign empty     = empty_w;
  assign busy      = (state_q == PROBE);
  assign err       = err_q;

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The module SHALL have parameter COLOR_W, default 2, meaning the card colour field width.
REQ-002 The module SHALL have parameter NUMBER_W, default 3, meaning the card number field width; IDX_W = COLOR_W+NUMBER_W, required IDX_W <= 16.
REQ-003 The module SHALL have parameter SEED, default 16'hACE1, meaning the non-zero LFSR reset value.
REQ-004 The module SHALL have derived localparam DECK_SIZE = 2**IDX_W and CNT_W = IDX_W+1.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port req, input, 1 bit: deal request.
REQ-008 The module SHALL have port shuffle, input, 1 bit: return all cards to the deck.
REQ-009 The module SHALL have port valid, output, 1 bit: one-cycle pulse when a card is dealt.
REQ-010 The module SHALL have port color, output, COLOR_W bits: colour of the last dealt card.
REQ-011 The module SHALL have port number, output, NUMBER_W bits: number of the last dealt card.
REQ-012 The module SHALL have port remaining, output, CNT_W bits: count of undealt cards.
REQ-013 The module SHALL have port empty, output, 1 bit: high when remaining == 0.
REQ-014 The module SHALL have port busy, output, 1 bit: high while in PROBE.
REQ-015 The module SHALL have port err, output, 1 bit: one-cycle pulse when a request is refused.

Function
REQ-016 A 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL advance every cycle, free-running, never zero.
REQ-017 A DECK_SIZE-bit used bitmap SHALL record dealt cards; index i maps to color = i[IDX_W-1:NUMBER_W], number = i[NUMBER_W-1:0].
REQ-018 The FSM SHALL have states IDLE and PROBE; busy = (state == PROBE).
REQ-019 In IDLE, with shuffle=1: clear bitmap, remaining = DECK_SIZE, ignore req that cycle (shuffle wins).
REQ-020 In IDLE, with req=1, shuffle=0 and empty=0: latch idx = lfsr[IDX_W-1:0] and go to PROBE.
REQ-021 In PROBE, if used[idx]==0: set used[idx], register color/number from idx, pulse valid, decrement remaining, return to IDLE; all of this at the same edge.
REQ-022 In PROBE, if used[idx]==1: idx = idx+1, wrapping DECK_SIZE-1 -> 0; stay in PROBE.
REQ-023 Latency: valid SHALL be high in cycle N+k+1 for a request accepted at edge N, 1 <= k <= DECK_SIZE; worst case occurs with one card left.
REQ-024 While in PROBE, req and shuffle SHALL be ignored (not queued).
REQ-025 color and number SHALL hold their value between deals; valid SHALL never exceed one cycle per accepted request.
REQ-026 No card SHALL be dealt twice between shuffles/refills; remaining SHALL never underflow.

Reset
REQ-027 When rst is low, the module SHALL asynchronously force state=IDLE, bitmap clear, LFSR=SEED, remaining=DECK_SIZE, and valid/err/color/number/busy=0, empty=0.
REQ-028 A reset asserted during PROBE SHALL abort the deal; no valid pulse follows, and the partially probed index is discarded.

Configuration
REQ-029 Macro CARD_DEALER_AUTO_REFILL_EN: when defined, a req in IDLE with empty=1 and shuffle=0 SHALL clear the bitmap, set remaining=DECK_SIZE, latch idx from the LFSR and enter PROBE in the same edge, without pulsing err.
REQ-030 When CARD_DEALER_AUTO_REFILL_EN is undefined, such a req SHALL pulse err for one cycle, stay in IDLE, and leave remaining=0 and outputs unchanged.

Verification
REQ-031 Defaults, reset, 32 sequential reqs each awaiting valid -> 32 distinct {color,number} pairs, remaining 32->0, empty=1 after the 32nd.
REQ-032 33rd req -> macro off: err high 1 cycle, no valid, remaining=0; macro on: one valid, remaining=31, empty=0.
REQ-033 10 deals, then shuffle in IDLE -> remaining=32 next cycle, next 32 deals all distinct.
REQ-034 req held high for 3 cycles from IDLE, plus req while busy -> exactly one valid per IDLE acceptance, none for requests during PROBE.
REQ-035 rst low during PROBE, then released -> valid stays 0, remaining=32, busy=0, LFSR=16'hACE1.
REQ-036 COLOR_W=1, NUMBER_W=2, deal 8 -> 8 distinct cards; force a probe starting at index 7 with 7 used -> idx wraps to 0, with latency covering the wrap.
